// File: rtl/md5_step_engine.sv
// ---------------------------------------------------------------------------
// md5_step_engine
// Iterative MD5 compression core. It applies all 64 MD5 steps to one 512-bit
// message block and then adds the chaining value. STEPS_PER_CYCLE steps are
// chained combinationally per clock (1, 2 or 4), trading throughput for area.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous, active-high reset
//   start      compress request, sampled only while busy=0
//   msg_in     512-bit block, word i = msg_in[32*i+31:32*i]
//   state_in   chaining value, A=[31:0] B=[63:32] C=[95:64] D=[127:96]
//   busy       high from the cycle after acceptance through FIN
//   done       one-cycle pulse when digest_out updates
//   digest_out result, same packing as state_in, held until the next done
// ---------------------------------------------------------------------------
module md5_step_engine #(
   parameter int STEPS_PER_CYCLE = 1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic [511:0] msg_in,
   input  logic [127:0] state_in,
   output logic         busy,
   output logic         done,
   output logic [127:0] digest_out
);

   // Only divisors of 16 that keep the per-round structure aligned are legal.
   generate
      if (!(STEPS_PER_CYCLE == 1 || STEPS_PER_CYCLE == 2 || STEPS_PER_CYCLE == 4)) begin : g_bad_steps
         $error("md5_step_engine: STEPS_PER_CYCLE must be 1, 2 or 4");
      end
   endgenerate

   typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

   state_t        state;
   logic [5:0]    step;
   logic [511:0]  msg;
   logic [31:0]   iv_a, iv_b, iv_c, iv_d;
   logic [31:0]   a_reg, b_reg, c_reg, d_reg;
   logic [127:0]  chain;

   // K[j] = floor(|sin(j+1)| * 2^32)
   function automatic logic [31:0] k_rom(input logic [5:0] j);
      logic [31:0] k;
      case (j)
         6'd0:  k = 32'hd76aa478;  6'd1:  k = 32'he8c7b756;  6'd2:  k = 32'h242070db;  6'd3:  k = 32'hc1bdceee;
         6'd4:  k = 32'hf57c0faf;  6'd5:  k = 32'h4787c62a;  6'd6:  k = 32'ha8304613;  6'd7:  k = 32'hfd469501;
         6'd8:  k = 32'h698098d8;  6'd9:  k = 32'h8b44f7af;  6'd10: k = 32'hffff5bb1;  6'd11: k = 32'h895cd7be;
         6'd12: k = 32'h6b901122;  6'd13: k = 32'hfd987193;  6'd14: k = 32'ha679438e;  6'd15: k = 32'h49b40821;
         6'd16: k = 32'hf61e2562;  6'd17: k = 32'hc040b340;  6'd18: k = 32'h265e5a51;  6'd19: k = 32'he9b6c7aa;
         6'd20: k = 32'hd62f105d;  6'd21: k = 32'h02441453;  6'd22: k = 32'hd8a1e681;  6'd23: k = 32'he7d3fbc8;
         6'd24: k = 32'h21e1cde6;  6'd25: k = 32'hc33707d6;  6'd26: k = 32'hf4d50d87;  6'd27: k = 32'h455a14ed;
         6'd28: k = 32'ha9e3e905;  6'd29: k = 32'hfcefa3f8;  6'd30: k = 32'h676f02d9;  6'd31: k = 32'h8d2a4c8a;
         6'd32: k = 32'hfffa3942;  6'd33: k = 32'h8771f681;  6'd34: k = 32'h6d9d6122;  6'd35: k = 32'hfde5380c;
         6'd36: k = 32'ha4beea44;  6'd37: k = 32'h4bdecfa9;  6'd38: k = 32'hf6bb4b60;  6'd39: k = 32'hbebfbc70;
         6'd40: k = 32'h289b7ec6;  6'd41: k = 32'heaa127fa;  6'd42: k = 32'hd4ef3085;  6'd43: k = 32'h04881d05;
         6'd44: k = 32'hd9d4d039;  6'd45: k = 32'he6db99e5;  6'd46: k = 32'h1fa27cf8;  6'd47: k = 32'hc4ac5665;
         6'd48: k = 32'hf4292244;  6'd49: k = 32'h432aff97;  6'd50: k = 32'hab9423a7;  6'd51: k = 32'hfc93a039;
         6'd52: k = 32'h655b59c3;  6'd53: k = 32'h8f0ccc92;  6'd54: k = 32'hffeff47d;  6'd55: k = 32'h85845dd1;
         6'd56: k = 32'h6fa87e4f;  6'd57: k = 32'hfe2ce6e0;  6'd58: k = 32'ha3014314;  6'd59: k = 32'h4e0811a1;
         6'd60: k = 32'hf7537e82;  6'd61: k = 32'hbd3af235;  6'd62: k = 32'h2ad7d2bb;  default: k = 32'heb86d391;
      endcase
      return k;
   endfunction

   // Per-step rotate amount, selected by round and j mod 4.
   function automatic logic [4:0] shift_amt(input logic [5:0] j);
      logic [4:0] s;
      case ({j[5:4], j[1:0]})
         4'h0: s = 5'd7;   4'h1: s = 5'd12;  4'h2: s = 5'd17;  4'h3: s = 5'd22;
         4'h4: s = 5'd5;   4'h5: s = 5'd9;   4'h6: s = 5'd14;  4'h7: s = 5'd20;
         4'h8: s = 5'd4;   4'h9: s = 5'd11;  4'ha: s = 5'd16;  4'hb: s = 5'd23;
         4'hc: s = 5'd6;   4'hd: s = 5'd10;  4'he: s = 5'd15;  default: s = 5'd21;
      endcase
      return s;
   endfunction

   // Rotate amounts are always 1..31, so the right shift never reaches 32.
   function automatic logic [31:0] rotl32(input logic [31:0] x, input logic [4:0] n);
      return (x << n) | (x >> (6'd32 - {1'b0, n}));
   endfunction

   // One MD5 step; returns the updated working set packed as {A, B, C, D}.
   function automatic logic [127:0] md5_step(input logic [31:0] fa, input logic [31:0] fb,
                                             input logic [31:0] fc, input logic [31:0] fd,
                                             input logic [5:0] j, input logic [511:0] m);
      logic [31:0] f;
      logic [31:0] sum;
      logic [3:0]  g;
      case (j[5:4])
         2'd0: begin f = (fb & fc) | (~fb & fd);  g = j[3:0];               end
         2'd1: begin f = (fb & fd) | (fc & ~fd);  g = j[3:0] * 4'd5 + 4'd1; end
         2'd2: begin f = fb ^ fc ^ fd;            g = j[3:0] * 4'd3 + 4'd5; end
         default: begin f = fc ^ (fb | ~fd);      g = j[3:0] * 4'd7;        end
      endcase
      sum = fa + f + k_rom(j) + m[{g, 5'd0} +: 32];
      return {fd, fb + rotl32(sum, shift_amt(j)), fb, fc};
   endfunction

   // Chain STEPS_PER_CYCLE steps starting at the current step counter.
   always_comb begin
      chain = {a_reg, b_reg, c_reg, d_reg};
      for (int k = 0; k < STEPS_PER_CYCLE; k++) begin
         chain = md5_step(chain[127:96], chain[95:64], chain[63:32], chain[31:0],
                          step + 6'(k), msg);
      end
   end

   // Control FSM plus all datapath registers. RUN leaves once the step
   // counter has reached the final group; FIN adds the IV and pulses done.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         step       <= 6'd0;
         busy       <= 1'b0;
         done       <= 1'b0;
         digest_out <= 128'd0;
         msg        <= 512'd0;
         iv_a       <= 32'd0;
         iv_b       <= 32'd0;
         iv_c       <= 32'd0;
         iv_d       <= 32'd0;
         a_reg      <= 32'd0;
         b_reg      <= 32'd0;
         c_reg      <= 32'd0;
         d_reg      <= 32'd0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  msg   <= msg_in;
                  iv_a  <= state_in[31:0];
                  iv_b  <= state_in[63:32];
                  iv_c  <= state_in[95:64];
                  iv_d  <= state_in[127:96];
                  a_reg <= state_in[31:0];
                  b_reg <= state_in[63:32];
                  c_reg <= state_in[95:64];
                  d_reg <= state_in[127:96];
                  step  <= 6'd0;
                  busy  <= 1'b1;
                  state <= RUN;
               end
            end
            RUN: begin
               a_reg <= chain[127:96];
               b_reg <= chain[95:64];
               c_reg <= chain[63:32];
               d_reg <= chain[31:0];
               step  <= step + 6'(STEPS_PER_CYCLE);
               if (step == 6'(64 - STEPS_PER_CYCLE)) begin
                  state <= FIN;
               end
            end
            FIN: begin
               digest_out <= {d_reg + iv_d, c_reg + iv_c, b_reg + iv_b, a_reg + iv_a};
               done       <= 1'b1;
               busy       <= 1'b0;
               state      <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_md5_step_engine.sv
// ---------------------------------------------------------------------------
// tb_md5_step_engine
// Self-checking bench for md5_step_engine. Three instances (1, 2 and 4 steps
// per cycle) share clock, reset and data inputs; each has its own start.
// Expected digests are queued per instance when a block is launched and
// popped when that instance raises done.
// ---------------------------------------------------------------------------
module tb_md5_step_engine;

   localparam logic [127:0] IV        = {32'h10325476, 32'h98badcfe, 32'hefcdab89, 32'h67452301};
   localparam logic [511:0] MSG_EMPTY = 512'h80;
   localparam logic [511:0] MSG_ABC   = (512'h18 << 448) | 512'h80636261;
   localparam logic [127:0] DIG_EMPTY = {32'h7e42f8ec, 32'h980980e9, 32'h04b2008f, 32'hd98c1dd4};
   localparam logic [127:0] DIG_ABC   = {32'h727fe128, 32'h7d3f96d6, 32'hb04fd23c, 32'h98500190};

   logic         clk = 1'b0;
   logic         rst;
   logic [511:0] msg_in;
   logic [127:0] state_in;
   logic         start_v  [3];
   logic         busy_v   [3];
   logic         done_v   [3];
   logic [127:0] digest_v [3];

   int checks = 0;
   int errors = 0;

   logic [127:0] q0[$];
   logic [127:0] q1[$];
   logic [127:0] q2[$];

   always #5 clk = ~clk;

   md5_step_engine #(.STEPS_PER_CYCLE(1)) dut1 (
      .clk(clk), .rst(rst), .start(start_v[0]), .msg_in(msg_in), .state_in(state_in),
      .busy(busy_v[0]), .done(done_v[0]), .digest_out(digest_v[0]));

   md5_step_engine #(.STEPS_PER_CYCLE(2)) dut2 (
      .clk(clk), .rst(rst), .start(start_v[1]), .msg_in(msg_in), .state_in(state_in),
      .busy(busy_v[1]), .done(done_v[1]), .digest_out(digest_v[1]));

   md5_step_engine #(.STEPS_PER_CYCLE(4)) dut4 (
      .clk(clk), .rst(rst), .start(start_v[2]), .msg_in(msg_in), .state_in(state_in),
      .busy(busy_v[2]), .done(done_v[2]), .digest_out(digest_v[2]));

   // Reference compression; K comes from the sine definition, not a table.
   function automatic logic [127:0] ref_compress(input logic [511:0] m, input logic [127:0] iv);
      logic [31:0] a, b, c, d, f, k, tmp;
      int g, sh;
      real r;
      int shifts [4][4] = '{'{7, 12, 17, 22}, '{5, 9, 14, 20}, '{4, 11, 16, 23}, '{6, 10, 15, 21}};
      a = iv[31:0]; b = iv[63:32]; c = iv[95:64]; d = iv[127:96];
      for (int j = 0; j < 64; j++) begin
         case (j / 16)
            0: begin f = (b & c) | (~b & d); g = j;                end
            1: begin f = (d & b) | (~d & c); g = (5 * j + 1) % 16; end
            2: begin f = b ^ c ^ d;          g = (3 * j + 5) % 16; end
            default: begin f = c ^ (b | ~d); g = (7 * j) % 16;     end
         endcase
         r = $sin(real'(j + 1));
         if (r < 0.0) r = -r;
         k = 32'(longint'($floor(r * 4294967296.0)));
         sh = shifts[j / 16][j % 4];
         tmp = a + f + k + m[32 * g +: 32];
         tmp = (tmp << sh) | (tmp >> (32 - sh));
         a = d; d = c; c = b; b = b + tmp;
      end
      return {d + iv[127:96], c + iv[95:64], b + iv[63:32], a + iv[31:0]};
   endfunction

   // Launch a block on the 1-step instance; caller sits between edges.
   task automatic issue_start(input logic [511:0] m, input logic [127:0] iv, input logic [127:0] expv);
      msg_in     = m;
      state_in   = iv;
      start_v[0] = 1'b1;
      q0.push_back(expv);
      @(posedge clk);
      #1;
      start_v[0] = 1'b0;
      msg_in     = {16{32'hdeadbeef}};
      state_in   = {4{32'hcafef00d}};
   endtask

   // Wait (bounded) for done on the 1-step instance, counting edges and busy cycles.
   task automatic wait_done(output int cycles, output int busy_cycles, output bit seen);
      cycles = 0;
      busy_cycles = 0;
      seen = 1'b0;
      for (int n = 0; n < 200 && !seen; n++) begin
         @(negedge clk);
         if (done_v[0]) begin
            seen = 1'b1;
         end else begin
            if (busy_v[0]) busy_cycles++;
            @(posedge clk);
            cycles++;
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      msg_in = '0;
      state_in = '0;
      for (int u = 0; u < 3; u++) start_v[u] = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      for (int u = 0; u < 3; u++) begin
         checks++;
         if (busy_v[u] !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy u=%0d got %b expected 0", u, busy_v[u]); end
         checks++;
         if (done_v[u] !== 1'b0) begin errors++; $display("[TB] FAIL reset_done u=%0d got %b expected 0", u, done_v[u]); end
         checks++;
         if (digest_v[u] !== 128'd0) begin errors++; $display("[TB] FAIL reset_digest u=%0d got %h expected 0", u, digest_v[u]); end
      end
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_empty();
      int cyc, bcyc;
      bit seen;
      logic [127:0] expv, held;
      @(negedge clk);
      issue_start(MSG_EMPTY, IV, DIG_EMPTY);
      wait_done(cyc, bcyc, seen);
      checks++;
      if (!seen || cyc != 65) begin errors++; $display("[TB] FAIL empty_latency got %0d (seen=%0b) expected 65", cyc, seen); end
      checks++;
      if (bcyc != 65) begin errors++; $display("[TB] FAIL empty_busy_cycles got %0d expected 65", bcyc); end
      expv = (q0.size() > 0) ? q0.pop_front() : 128'hx;
      checks++;
      if (digest_v[0] !== expv) begin errors++; $display("[TB] FAIL empty_digest got %h expected %h", digest_v[0], expv); end
      held = expv;
      @(negedge clk);
      checks++;
      if (done_v[0] !== 1'b0) begin errors++; $display("[TB] FAIL empty_done_width got %b expected 0", done_v[0]); end
      checks++;
      if (digest_v[0] !== held) begin errors++; $display("[TB] FAIL empty_digest_hold got %h expected %h", digest_v[0], held); end
   endtask

   task automatic test_abc();
      int lat [3] = '{-1, -1, -1};
      int exp_lat [3] = '{65, 33, 17};
      logic [127:0] got [3];
      logic [127:0] expv;
      int cyc = 0;
      @(negedge clk);
      msg_in = MSG_ABC;
      state_in = IV;
      for (int u = 0; u < 3; u++) start_v[u] = 1'b1;
      q0.push_back(DIG_ABC);
      q1.push_back(DIG_ABC);
      q2.push_back(DIG_ABC);
      @(posedge clk);
      #1;
      for (int u = 0; u < 3; u++) start_v[u] = 1'b0;
      msg_in = '0;
      for (int n = 0; n < 100; n++) begin
         @(negedge clk);
         for (int u = 0; u < 3; u++) begin
            if (done_v[u] && lat[u] < 0) begin
               lat[u] = cyc;
               got[u] = digest_v[u];
            end
         end
         if (lat[0] >= 0 && lat[1] >= 0 && lat[2] >= 0) break;
         @(posedge clk);
         cyc++;
      end
      for (int u = 0; u < 3; u++) begin
         case (u)
            0: expv = (q0.size() > 0) ? q0.pop_front() : 128'hx;
            1: expv = (q1.size() > 0) ? q1.pop_front() : 128'hx;
            default: expv = (q2.size() > 0) ? q2.pop_front() : 128'hx;
         endcase
         checks++;
         if (lat[u] != exp_lat[u]) begin errors++; $display("[TB] FAIL abc_latency u=%0d got %0d expected %0d", u, lat[u], exp_lat[u]); end
         checks++;
         if (got[u] !== expv) begin errors++; $display("[TB] FAIL abc_digest u=%0d got %h expected %h", u, got[u], expv); end
      end
   endtask

   task automatic test_back_to_back();
      int cyc, bcyc;
      bit seen;
      logic [127:0] expv;
      @(negedge clk);
      issue_start(MSG_ABC, IV, DIG_ABC);
      wait_done(cyc, bcyc, seen);
      expv = (q0.size() > 0) ? q0.pop_front() : 128'hx;
      checks++;
      if (!seen || digest_v[0] !== expv) begin errors++; $display("[TB] FAIL b2b_first_digest got %h expected %h", digest_v[0], expv); end
      // Still inside the done cycle: launch the next block immediately.
      issue_start(MSG_EMPTY, IV, DIG_EMPTY);
      repeat (30) @(posedge clk);
      #1;
      checks++;
      if (digest_v[0] !== DIG_ABC) begin errors++; $display("[TB] FAIL b2b_hold got %h expected %h", digest_v[0], DIG_ABC); end
      wait_done(cyc, bcyc, seen);
      checks++;
      if (!seen || cyc != 35) begin errors++; $display("[TB] FAIL b2b_latency got %0d (seen=%0b) expected 35", cyc, seen); end
      expv = (q0.size() > 0) ? q0.pop_front() : 128'hx;
      checks++;
      if (digest_v[0] !== expv) begin errors++; $display("[TB] FAIL b2b_second_digest got %h expected %h", digest_v[0], expv); end
   endtask

   task automatic test_start_busy();
      int cyc, bcyc, pulses;
      bit seen;
      logic [127:0] expv;
      @(negedge clk);
      issue_start(MSG_ABC, IV, DIG_ABC);
      repeat (30) @(posedge clk);
      @(negedge clk);
      msg_in = MSG_EMPTY;
      state_in = DIG_EMPTY;
      start_v[0] = 1'b1;
      @(posedge clk);
      #1;
      start_v[0] = 1'b0;
      wait_done(cyc, bcyc, seen);
      checks++;
      if (!seen || cyc != 34) begin errors++; $display("[TB] FAIL busy_start_latency got %0d (seen=%0b) expected 34", cyc, seen); end
      expv = (q0.size() > 0) ? q0.pop_front() : 128'hx;
      checks++;
      if (digest_v[0] !== expv) begin errors++; $display("[TB] FAIL busy_start_digest got %h expected %h", digest_v[0], expv); end
      pulses = 0;
      repeat (80) begin
         @(posedge clk);
         @(negedge clk);
         if (done_v[0]) pulses++;
      end
      checks++;
      if (pulses != 0) begin errors++; $display("[TB] FAIL busy_start_extra_done got %0d expected 0", pulses); end
      checks++;
      if (digest_v[0] !== DIG_ABC) begin errors++; $display("[TB] FAIL busy_start_digest_hold got %h expected %h", digest_v[0], DIG_ABC); end
   endtask

   task automatic test_reset_mid();
      int cyc, bcyc, pulses;
      bit seen;
      logic [127:0] expv;
      @(negedge clk);
      issue_start(MSG_EMPTY, IV, DIG_EMPTY);
      repeat (40) @(posedge clk);
      #3;
      rst = 1'b1;
      void'(q0.pop_back());
      #1;
      checks++;
      if (busy_v[0] !== 1'b0) begin errors++; $display("[TB] FAIL midreset_busy got %b expected 0", busy_v[0]); end
      checks++;
      if (done_v[0] !== 1'b0) begin errors++; $display("[TB] FAIL midreset_done got %b expected 0", done_v[0]); end
      checks++;
      if (digest_v[0] !== 128'd0) begin errors++; $display("[TB] FAIL midreset_digest got %h expected 0", digest_v[0]); end
      @(negedge clk);
      rst = 1'b0;
      pulses = 0;
      repeat (80) begin
         @(posedge clk);
         @(negedge clk);
         if (done_v[0] || busy_v[0]) pulses++;
      end
      checks++;
      if (pulses != 0) begin errors++; $display("[TB] FAIL midreset_activity got %0d expected 0", pulses); end
      issue_start(MSG_EMPTY, IV, DIG_EMPTY);
      wait_done(cyc, bcyc, seen);
      checks++;
      if (!seen || cyc != 65) begin errors++; $display("[TB] FAIL midreset_restart_latency got %0d (seen=%0b) expected 65", cyc, seen); end
      expv = (q0.size() > 0) ? q0.pop_front() : 128'hx;
      checks++;
      if (digest_v[0] !== expv) begin errors++; $display("[TB] FAIL midreset_restart_digest got %h expected %h", digest_v[0], expv); end
   endtask

   task automatic test_chaining();
      int cyc, bcyc;
      bit seen;
      logic [127:0] expv;
      @(negedge clk);
      issue_start(MSG_EMPTY, DIG_EMPTY, ref_compress(MSG_EMPTY, DIG_EMPTY));
      wait_done(cyc, bcyc, seen);
      expv = (q0.size() > 0) ? q0.pop_front() : 128'hx;
      checks++;
      if (!seen || digest_v[0] !== expv) begin errors++; $display("[TB] FAIL chain_empty got %h expected %h", digest_v[0], expv); end
      @(negedge clk);
      issue_start(MSG_ABC, DIG_ABC, ref_compress(MSG_ABC, DIG_ABC));
      wait_done(cyc, bcyc, seen);
      expv = (q0.size() > 0) ? q0.pop_front() : 128'hx;
      checks++;
      if (!seen || digest_v[0] !== expv) begin errors++; $display("[TB] FAIL chain_abc got %h expected %h", digest_v[0], expv); end
   endtask

   initial begin
      test_reset();
      test_empty();
      test_abc();
      test_back_to_back();
      test_start_busy();
      test_reset_mid();
      test_chaining();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
